// File: rtl/sandbox_pkg.sv
// Shared types for the two-copy commit-alignment sandbox: owner encoding,
// buffered commit entry and small helpers used by the scheduler.
package sandbox_pkg;

  localparam int unsigned DataLen = 32;

  typedef enum logic [1:0] {
    OwnerNone  = 2'd0,
    OwnerCopy1 = 2'd1,
    OwnerCopy2 = 2'd2
  } owner_t;

  typedef struct packed {
    logic               ismem;
    logic [DataLen-1:0] ldata;
  } commit_ent_t;

  // Misprediction or stall kills the whole cycle; encoding 3 saturates to 2.
  function automatic logic [1:0] eff_count(input logic [1:0] comnum, input logic kill);
    if (kill) return 2'd0;
    return (comnum == 2'd3) ? 2'd2 : comnum;
  endfunction

  function automatic logic ent_mismatch(input commit_ent_t a, input commit_ent_t b);
    return a.ismem && b.ismem && (a.ldata != b.ldata);
  endfunction

endpackage

// File: rtl/commit_fifo.sv
// Circular buffer of leader commits: up to two pops and two pushes per cycle,
// with flush-then-push for owner flips. Exposes the two head entries.
module commit_fifo
  import sandbox_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                       clk,
  input  logic                       reset_x,
  input  logic                       flush,
  input  logic [1:0]                 pop_cnt,
  input  logic [1:0]                 push_cnt,
  input  commit_ent_t                push0,
  input  commit_ent_t                push1,
  output commit_ent_t                head0,
  output commit_ent_t                head1,
  output logic [$clog2(Depth+1)-1:0] count
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  commit_ent_t     mem_q [Depth];
  logic [PtrW-1:0] rd_q, wr_q, rd_d, wr_d, wr_base;
  logic [CntW-1:0] cnt_q, cnt_d;

  function automatic logic [PtrW-1:0] ptr_add(input logic [PtrW-1:0] p, input logic [1:0] inc);
    logic [PtrW:0] s;
    s = (PtrW+1)'(p) + (PtrW+1)'(inc);
    if (s >= (PtrW+1)'(Depth)) s = s - (PtrW+1)'(Depth);
    return s[PtrW-1:0];
  endfunction

  always_comb begin
    rd_d    = flush ? '0 : ptr_add(rd_q, pop_cnt);
    wr_base = flush ? '0 : wr_q;
    wr_d    = ptr_add(wr_base, push_cnt);
    cnt_d   = (flush ? '0 : cnt_q - CntW'(pop_cnt)) + CntW'(push_cnt);
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_cnt != 2'd0) mem_q[wr_base] <= push0;
    if (push_cnt == 2'd2) mem_q[ptr_add(wr_base, 2'd1)] <= push1;
  end

  assign head0 = mem_q[rd_q];
  assign head1 = mem_q[ptr_add(rd_q, 2'd1)];
  assign count = cnt_q;

endmodule

// File: rtl/two_copy_commit_sched.sv
// Aligns the commit streams of two core copies: buffers the leader's commits,
// pairs them in order against the lagger, and gates the leader when the buffer
// nears full. Optional ADDR_OBSV_EN adds data-address comparison.
module two_copy_commit_sched
  import sandbox_pkg::*;
#(
  parameter int unsigned DATA_LEN   = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset_x,
  input  logic [1:0]                      c1_comnum,
  input  logic                            c1_prmiss,
  input  logic [1:0]                      c1_ismem,
  input  logic [DATA_LEN-1:0]             c1_ldata0,
  input  logic [DATA_LEN-1:0]             c1_ldata1,
  input  logic [1:0]                      c2_comnum,
  input  logic                            c2_prmiss,
  input  logic [1:0]                      c2_ismem,
  input  logic [DATA_LEN-1:0]             c2_ldata0,
  input  logic [DATA_LEN-1:0]             c2_ldata1,
`ifdef ADDR_OBSV_EN
  input  logic [31:0]                     c1_dmem_addr,
  input  logic [31:0]                     c2_dmem_addr,
`endif
  output logic                            stall_1,
  output logic                            stall_2,
  output logic                            commit_deviation,
  output logic                            invalid_program,
  output logic                            deviation_found,
  output logic [1:0]                      owner,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] occupancy
);

  localparam int unsigned OW = $clog2(FIFO_DEPTH + 1);
  // Sequence length reaches FIFO_DEPTH + 2 (full queue plus two new commits).
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 3);

  owner_t owner_q, owner_d;
  logic   stall_1_q, stall_2_q, commit_dev_q, invalid_q;

  commit_ent_t new1 [2];
  commit_ent_t new2 [2];
  commit_ent_t s1 [2];
  commit_ent_t s2 [2];
  commit_ent_t win_new [2];
  commit_ent_t qh [2];
  commit_ent_t push0, push1;

  logic [1:0]    n1, n2, win_n, pop_cnt, push_cnt;
  logic [OW-1:0] fifo_cnt;
  logic [LW-1:0] occ1, occ2, len1, len2, k, win_occ, st, occ_d;
  logic          mismatch, flush;

  always_comb begin
    n1 = eff_count(c1_comnum, stall_1_q | c1_prmiss);
    n2 = eff_count(c2_comnum, stall_2_q | c2_prmiss);
    new1[0] = '{ismem: c1_ismem[0], ldata: c1_ldata0};
    new1[1] = '{ismem: c1_ismem[1], ldata: c1_ldata1};
    new2[0] = '{ismem: c2_ismem[0], ldata: c2_ldata0};
    new2[1] = '{ismem: c2_ismem[1], ldata: c2_ldata1};

    occ1 = (owner_q == OwnerCopy1) ? LW'(fifo_cnt) : '0;
    occ2 = (owner_q == OwnerCopy2) ? LW'(fifo_cnt) : '0;
    len1 = occ1 + LW'(n1);
    len2 = occ2 + LW'(n2);
    k    = (len1 < len2) ? len1 : len2;

    // Only the first two positions of each sequence can ever be paired.
    s1[0] = (occ1 != '0) ? qh[0] : new1[0];
    s1[1] = (occ1 >= LW'(2)) ? qh[1] : ((occ1 == LW'(1)) ? new1[0] : new1[1]);
    s2[0] = (occ2 != '0) ? qh[0] : new2[0];
    s2[1] = (occ2 >= LW'(2)) ? qh[1] : ((occ2 == LW'(1)) ? new2[0] : new2[1]);

    mismatch = 1'b0;
    if (k >= LW'(1) && ent_mismatch(s1[0], s2[0])) mismatch = 1'b1;
    if (k >= LW'(2) && ent_mismatch(s1[1], s2[1])) mismatch = 1'b1;

    owner_d    = OwnerNone;
    win_occ    = '0;
    win_n      = 2'd0;
    win_new[0] = new1[0];
    win_new[1] = new1[1];
    occ_d      = '0;
    if (len1 > len2) begin
      owner_d = OwnerCopy1;
      win_occ = occ1;
      win_n   = n1;
      occ_d   = len1 - k;
    end else if (len2 > len1) begin
      owner_d    = OwnerCopy2;
      win_occ    = occ2;
      win_n      = n2;
      win_new[0] = new2[0];
      win_new[1] = new2[1];
      occ_d      = len2 - k;
    end

    // A new owner always finds the old queue fully consumed, so flush is exact.
    flush    = (owner_d != owner_q);
    pop_cnt  = flush ? 2'd0 : ((k < win_occ) ? 2'(k) : 2'(win_occ));
    st       = (k > win_occ) ? (k - win_occ) : '0;
    push_cnt = (owner_d == OwnerNone) ? 2'd0 : (win_n - 2'(st));
    push0    = (st == '0) ? win_new[0] : win_new[1];
    push1    = win_new[1];
  end

  commit_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_x (reset_x),
    .flush   (flush),
    .pop_cnt (pop_cnt),
    .push_cnt(push_cnt),
    .push0   (push0),
    .push1   (push1),
    .head0   (qh[0]),
    .head1   (qh[1]),
    .count   (fifo_cnt)
  );

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      owner_q      <= OwnerNone;
      stall_1_q    <= 1'b0;
      stall_2_q    <= 1'b0;
      commit_dev_q <= 1'b0;
      invalid_q    <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      stall_1_q    <= (owner_d == OwnerCopy1) && (occ_d > LW'(FIFO_DEPTH - 2));
      stall_2_q    <= (owner_d == OwnerCopy2) && (occ_d > LW'(FIFO_DEPTH - 2));
      commit_dev_q <= commit_dev_q | (occ_d != '0);
      invalid_q    <= invalid_q | mismatch;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_x)
                                  occ_d <= LW'(FIFO_DEPTH));

`ifdef ADDR_OBSV_EN
  logic addr_dev_q;
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      addr_dev_q <= 1'b0;
    end else if (!stall_1_q && !stall_2_q && (c1_dmem_addr != c2_dmem_addr)) begin
      addr_dev_q <= 1'b1;
    end
  end
  assign deviation_found = commit_dev_q | addr_dev_q;
`else
  assign deviation_found = commit_dev_q;
`endif

  assign stall_1          = stall_1_q;
  assign stall_2          = stall_2_q;
  assign commit_deviation = commit_dev_q;
  assign invalid_program  = invalid_q;
  assign owner            = owner_q;
  assign occupancy        = fifo_cnt;

endmodule

// File: tb/tb_two_copy_commit_sched.sv
// Directed bench for two_copy_commit_sched (FIFO_DEPTH=4, ADDR_OBSV_EN undefined).
module tb_two_copy_commit_sched;

  logic        clk = 1'b0;
  logic        reset_x;
  logic [1:0]  c1_comnum, c2_comnum, c1_ismem, c2_ismem;
  logic        c1_prmiss, c2_prmiss;
  logic [31:0] c1_ldata0, c1_ldata1, c2_ldata0, c2_ldata1;
`ifdef ADDR_OBSV_EN
  logic [31:0] c1_dmem_addr = '0;
  logic [31:0] c2_dmem_addr = '0;
`endif
  logic        stall_1, stall_2, commit_deviation, invalid_program, deviation_found;
  logic [1:0]  owner;
  logic [2:0]  occupancy;

  int checks = 0;
  int failures = 0;

  // {owner, occupancy, stall_1, stall_2, commit_deviation, invalid_program, deviation_found}
  logic [9:0] obs, e;
  assign obs = {owner, occupancy, stall_1, stall_2, commit_deviation, invalid_program,
                deviation_found};

  two_copy_commit_sched #(
    .DATA_LEN  (32),
    .FIFO_DEPTH(4)
  ) dut (
    .clk             (clk),
    .reset_x         (reset_x),
    .c1_comnum       (c1_comnum),
    .c1_prmiss       (c1_prmiss),
    .c1_ismem        (c1_ismem),
    .c1_ldata0       (c1_ldata0),
    .c1_ldata1       (c1_ldata1),
    .c2_comnum       (c2_comnum),
    .c2_prmiss       (c2_prmiss),
    .c2_ismem        (c2_ismem),
    .c2_ldata0       (c2_ldata0),
    .c2_ldata1       (c2_ldata1),
`ifdef ADDR_OBSV_EN
    .c1_dmem_addr    (c1_dmem_addr),
    .c2_dmem_addr    (c2_dmem_addr),
`endif
    .stall_1         (stall_1),
    .stall_2         (stall_2),
    .commit_deviation(commit_deviation),
    .invalid_program (invalid_program),
    .deviation_found (deviation_found),
    .owner           (owner),
    .occupancy       (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] xp(input logic [1:0] o, input logic [2:0] occ, input logic s1,
                                    input logic s2, input logic cd, input logic ip);
    return {o, occ, s1, s2, cd, ip, cd};
  endfunction

  task automatic drive(input logic [1:0] an, input logic [1:0] am, input logic [31:0] a0,
                       input logic [31:0] a1, input logic [1:0] bn, input logic [1:0] bm,
                       input logic [31:0] b0, input logic [31:0] b1);
    c1_comnum = an; c1_ismem = am; c1_ldata0 = a0; c1_ldata1 = a1; c1_prmiss = 1'b0;
    c2_comnum = bn; c2_ismem = bm; c2_ldata0 = b0; c2_ldata1 = b1; c2_prmiss = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_x = 1'b0;
    drive(2'd0, 2'd0, 32'h0, 32'h0, 2'd0, 2'd0, 32'h0, 32'h0);
    step();
    reset_x = 1'b1;
  endtask

  task automatic test_reset();
    reset_x = 1'b0;
    drive(2'd2, 2'd3, 32'h1, 32'h2, 2'd0, 2'd0, 32'h0, 32'h0);
    #2;
    e = xp(2'd0, 3'd0, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL reset_async obs=%b exp=%b", obs, e); end
    step();
    checks++;
    if (obs !== e) begin failures++; $display("FAIL reset_hold obs=%b exp=%b", obs, e); end
    reset_x = 1'b1;
  endtask

  task automatic test_lockstep();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      drive(2'd2, 2'd3, 32'h100 + i, 32'h200 + i, 2'd2, 2'd3, 32'h100 + i, 32'h200 + i);
      step();
      e = xp(2'd0, 3'd0, 0, 0, 0, 0);
      checks++;
      if (obs !== e) begin failures++; $display("FAIL lockstep_%0d obs=%b exp=%b", i, obs, e); end
    end
  endtask

  task automatic test_lead();
    apply_reset();
    drive(2'd2, 2'b01, 32'hA0, 32'hA1, 2'd0, 2'd0, 32'h0, 32'h0);
    step();
    e = xp(2'd1, 3'd2, 0, 0, 1, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL lead_1 obs=%b exp=%b", obs, e); end
    drive(2'd2, 2'b11, 32'hB0, 32'hB1, 2'd0, 2'd0, 32'h0, 32'h0);
    step();
    e = xp(2'd1, 3'd4, 1, 0, 1, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL lead_2 obs=%b exp=%b", obs, e); end
    // Stalled copy1 offers commits that must be ignored.
    drive(2'd2, 2'b11, 32'hFFFF, 32'hFFFF, 2'd0, 2'd0, 32'h0, 32'h0);
    step();
    checks++;
    if (obs !== e) begin failures++; $display("FAIL lead_stalled obs=%b exp=%b", obs, e); end
    drive(2'd2, 2'b11, 32'hFFFF, 32'hFFFF, 2'd2, 2'b11, 32'hA0, 32'h1234);
    step();
    e = xp(2'd1, 3'd2, 0, 0, 1, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL lead_drain obs=%b exp=%b", obs, e); end
    drive(2'd0, 2'b00, 32'h0, 32'h0, 2'd2, 2'b11, 32'hB0, 32'hB0);
    step();
    e = xp(2'd0, 3'd0, 0, 0, 1, 1);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL lead_mismatch obs=%b exp=%b", obs, e); end
  endtask

  task automatic test_lead_copy2();
    apply_reset();
    drive(2'd0, 2'd0, 32'h0, 32'h0, 2'd3, 2'b00, 32'h5, 32'h6);
    step();
    step();
    e = xp(2'd2, 3'd4, 0, 1, 1, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL lead2 obs=%b exp=%b", obs, e); end
  endtask

  task automatic test_catchup_mismatch();
    apply_reset();
    drive(2'd1, 2'b01, 32'hAAAA, 32'h0, 2'd0, 2'd0, 32'h0, 32'h0);
    step();
    e = xp(2'd1, 3'd1, 0, 0, 1, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL catchup_q obs=%b exp=%b", obs, e); end
    drive(2'd0, 2'b00, 32'h0, 32'h0, 2'd1, 2'b01, 32'hBBBB, 32'h0);
    step();
    e = xp(2'd0, 3'd0, 0, 0, 1, 1);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL catchup_mm obs=%b exp=%b", obs, e); end
  endtask

  task automatic test_owner_flip();
    apply_reset();
    drive(2'd1, 2'b00, 32'h1, 32'h0, 2'd0, 2'd0, 32'h0, 32'h0);
    step();
    drive(2'd0, 2'b00, 32'h0, 32'h0, 2'd2, 2'b11, 32'h55, 32'h66);
    step();
    e = xp(2'd2, 3'd1, 0, 0, 1, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL flip_to2 obs=%b exp=%b", obs, e); end
    drive(2'd2, 2'b01, 32'h66, 32'h7, 2'd0, 2'd0, 32'h0, 32'h0);
    step();
    e = xp(2'd1, 3'd1, 0, 0, 1, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL flip_to1 obs=%b exp=%b", obs, e); end
  endtask

  task automatic test_prmiss();
    apply_reset();
    drive(2'd2, 2'b11, 32'h9, 32'h9, 2'd2, 2'b11, 32'h10, 32'h20);
    c1_prmiss = 1'b1;
    step();
    e = xp(2'd2, 3'd2, 0, 0, 1, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL prmiss_1 obs=%b exp=%b", obs, e); end
    c2_prmiss = 1'b1;
    step();
    checks++;
    if (obs !== e) begin failures++; $display("FAIL prmiss_both obs=%b exp=%b", obs, e); end
    drive(2'd3, 2'b11, 32'h10, 32'h20, 2'd0, 2'd0, 32'h0, 32'h0);
    step();
    e = xp(2'd0, 3'd0, 0, 0, 1, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL comnum3 obs=%b exp=%b", obs, e); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive(2'd2, 2'b00, 32'h0, 32'h0, 2'd0, 2'd0, 32'h0, 32'h0);
    step();
    step();
    e = xp(2'd1, 3'd4, 1, 0, 1, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL pre_areset obs=%b exp=%b", obs, e); end
    #3;
    reset_x = 1'b0;
    #1;
    e = xp(2'd0, 3'd0, 0, 0, 0, 0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL areset obs=%b exp=%b", obs, e); end
    step();
    reset_x = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lockstep();
    test_lead();
    test_lead_copy2();
    test_catchup_mismatch();
    test_owner_flip();
    test_prmiss();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
